// File: rtl/uart_cmd_ctrl.sv
// Host command sequencer: parses framed UART commands into image-memory writes, erase fills
// and configuration updates, and reports a one-cycle ok/error status per frame.
module uart_cmd_ctrl #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned TIMEOUT_CLK = 1145870
) (
  input  logic              clk_s,
  input  logic              rst_s,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [7:0]        cfg_out,
  output logic              busy,
  output logic              cmd_ok,
  output logic              cmd_err,
  output logic [1:0]        err_code
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CLK + 1);

  localparam logic [7:0] Sync   = 8'hA5;
  localparam logic [7:0] OpWr   = 8'h57;
  localparam logic [7:0] OpEr   = 8'h45;
  localparam logic [7:0] OpCfg  = 8'h43;

  typedef enum logic [3:0] {
    StIdle, StOpc, StA2, StA1, StA0, StLen, StData, StVal, StChk, StErase
  } state_e;

  state_e            state_q;
  logic [7:0]        opc_q, sum_q, val_q;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        len_q;
  logic [TmoW-1:0]   tmo_q;
  logic              ovr_q, drain_q;

  logic accept, pending, counting, timeout, ovr_now;

  assign accept   = mem_we && mem_ready;
  assign pending  = mem_we && !mem_ready;
  assign counting = (state_q != StIdle) && (state_q != StErase);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout  = counting && !rx_done && (tmo_q == TmoW'(TIMEOUT_CLK));
  assign ovr_now  = ovr_q || rx_done;
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_q   <= StIdle;
      opc_q     <= '0;
      sum_q     <= '0;
      val_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      tmo_q     <= '0;
      ovr_q     <= 1'b0;
      drain_q   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cfg_out   <= '0;
      cmd_ok    <= 1'b0;
      cmd_err   <= 1'b0;
      err_code  <= '0;
    end else begin
      cmd_ok  <= 1'b0;
      cmd_err <= 1'b0;
      if (accept) mem_we <= 1'b0;

      if (rx_done || !counting) tmo_q <= '0;
      else                      tmo_q <= tmo_q + TmoW'(1);

      if (timeout) begin
        // Abandon any pending write; an overrun drain has already reported its error.
        state_q <= StIdle;
        mem_we  <= 1'b0;
        drain_q <= 1'b0;
        if (!drain_q) begin
          cmd_err  <= 1'b1;
          err_code <= 2'd2;
        end
      end else begin
        case (state_q)
          StIdle: begin
            if (rx_done && rx_data == Sync) begin
              state_q <= StOpc;
              sum_q   <= '0;
              ovr_q   <= 1'b0;
              drain_q <= 1'b0;
            end
          end
          StOpc: begin
            if (rx_done) begin
              opc_q <= rx_data;
              sum_q <= rx_data;
              if (rx_data == OpWr || rx_data == OpEr) begin
                state_q <= StA2;
              end else if (rx_data == OpCfg) begin
                state_q <= StVal;
              end else begin
                state_q  <= StIdle;
                cmd_err  <= 1'b1;
                err_code <= 2'd0;
              end
            end
          end
          StA2, StA1, StA0: begin
            if (rx_done) begin
              addr_q  <= ADDR_W'({addr_q, rx_data});
              sum_q   <= sum_q + rx_data;
              state_q <= (state_q == StA2) ? StA1 : (state_q == StA1) ? StA0 : StLen;
            end
          end
          StLen: begin
            if (rx_done) begin
              len_q   <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
              sum_q   <= sum_q + rx_data;
              state_q <= (opc_q == OpWr) ? StData : StChk;
            end
          end
          StVal: begin
            if (rx_done) begin
              val_q   <= rx_data;
              sum_q   <= sum_q + rx_data;
              state_q <= StChk;
            end
          end
          StData: begin
            if (drain_q) begin
              if (accept) begin
                state_q <= StIdle;
                drain_q <= 1'b0;
              end
            end else if (rx_done) begin
              if (pending) begin
                cmd_err  <= 1'b1;
                err_code <= 2'd3;
                drain_q  <= 1'b1;
              end else begin
                mem_addr  <= addr_q;
                mem_wdata <= rx_data;
                mem_we    <= 1'b1;
                addr_q    <= addr_q + ADDR_W'(1);
                sum_q     <= sum_q + rx_data;
                len_q     <= len_q - 9'd1;
                if (len_q == 9'd1) state_q <= StChk;
              end
            end
          end
          StChk: begin
            if (rx_done) begin
              if (rx_data != sum_q) begin
                state_q  <= StIdle;
                cmd_err  <= 1'b1;
                err_code <= 2'd1;
              end else if (opc_q == OpEr) begin
                state_q   <= StErase;
                mem_addr  <= addr_q;
                mem_wdata <= 8'hFF;
                mem_we    <= 1'b1;
              end else begin
                state_q <= StIdle;
                cmd_ok  <= 1'b1;
                if (opc_q == OpCfg) cfg_out <= val_q;
              end
            end
          end
          StErase: begin
            if (rx_done) ovr_q <= 1'b1;
            if (accept) begin
              if (len_q > 9'd1) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                mem_we   <= 1'b1;
                len_q    <= len_q - 9'd1;
              end else begin
                state_q <= StIdle;
                cmd_ok  <= !ovr_now;
                cmd_err <= ovr_now;
                if (ovr_now) err_code <= 2'd3;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: a frame-level model queues expected writes and status
// pulses, and a negedge monitor checks them as the DUT produces them.
module tb_uart_cmd_ctrl;

  localparam int unsigned AW  = 24;
  localparam int unsigned TMO = 200;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  typedef struct packed {
    logic       err;
    logic [1:0] code;
    logic [7:0] cfg;
  } rsp_t;

  logic          clk_s = 1'b0;
  logic          rst_s = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_done = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          mem_ready = 1'b1;
  logic [7:0]    cfg_out;
  logic          busy, cmd_ok, cmd_err;
  logic [1:0]    err_code;

  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;
  logic [7:0] cfg_exp = 8'h00;
  wr_t  wr_q[$];
  rsp_t rsp_q[$];

  uart_cmd_ctrl #(.ADDR_W(AW), .TIMEOUT_CLK(TMO)) dut (
    .clk_s(clk_s), .rst_s(rst_s), .rx_data(rx_data), .rx_done(rx_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
    .cfg_out(cfg_out), .busy(busy), .cmd_ok(cmd_ok), .cmd_err(cmd_err), .err_code(err_code)
  );

  always #5 clk_s = ~clk_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  function automatic void push_rsp(input logic e, input logic [1:0] c);
    rsp_t r;
    r.err  = e;
    r.code = c;
    r.cfg  = cfg_exp;
    rsp_q.push_back(r);
  endfunction

  // Reference model of one frame, then drive it; returns in the cycle after the last byte.
  task automatic run_frame(input logic [7:0] f[$], input bit inject, input int stall_idx);
    logic [7:0]    opc, sum;
    logic [AW-1:0] a;
    wr_t           w;
    bit            good;
    int            len;
    opc = f[1];
    sum = 8'h00;
    for (int i = 1; i < f.size() - 1; i++) sum = sum + f[i];
    good = (f[f.size()-1] == sum);
    len  = 0;
    if (opc == 8'h57 || opc == 8'h45) begin
      a   = {f[2], f[3], f[4]};
      len = (f[5] == 8'h00) ? 256 : int'(f[5]);
    end
    case (opc)
      8'h57: begin
        for (int i = 0; i < len; i++) begin
          w.addr = a + AW'(i);
          w.data = f[6+i];
          wr_q.push_back(w);
        end
        push_rsp(!good, good ? 2'd0 : 2'd1);
      end
      8'h45: begin
        if (good) begin
          for (int i = 0; i < len; i++) begin
            w.addr = a + AW'(i);
            w.data = 8'hFF;
            wr_q.push_back(w);
          end
          push_rsp(inject, inject ? 2'd3 : 2'd0);
        end else begin
          push_rsp(1'b1, 2'd1);
        end
      end
      8'h43: begin
        if (good) cfg_exp = f[2];
        push_rsp(!good, good ? 2'd0 : 2'd1);
      end
      default: push_rsp(1'b1, 2'd0);
    endcase
    for (int i = 0; i < f.size(); i++) begin
      if (i == stall_idx) begin
        repeat (TMO) tick();
        check("stall_still_busy", {31'd0, busy}, 32'd1);
      end else if (i > 1) begin
        repeat ($urandom_range(0, 3)) tick();
      end
      if (opc == 8'h57 && i >= 6 && i < 6 + len) begin
        while (mem_we) tick();
      end
      send_byte(f[i]);
    end
    if (inject) send_byte(8'h00);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((wr_q.size() != 0 || rsp_q.size() != 0 || busy) && n < 6000) begin
      tick();
      n++;
    end
    if (n >= 6000) begin
      checks++;
      errors++;
      $display("FAIL %s: frame did not complete, %0d writes and %0d responses outstanding",
               name, wr_q.size(), rsp_q.size());
      wr_q.delete();
      rsp_q.delete();
    end
    tick();
  endtask

  initial forever begin
    @(posedge clk_s);
    #2;
    case (rdy_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = 1'($urandom_range(0, 1));
      2:       mem_ready = ~mem_ready;
      default: mem_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every accepted write and every status pulse.
  logic          prev_hold = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [7:0]    prev_data;
  always @(negedge clk_s) begin
    wr_t  w;
    rsp_t r;
    if (rst_s) begin
      prev_hold = 1'b0;
    end else begin
      if (cmd_ok && cmd_err) begin
        checks++;
        errors++;
        $display("FAIL ok_err_exclusive: got both cmd_ok and cmd_err high");
      end
      if (prev_hold && mem_we) begin
        check("hold_addr", 32'(mem_addr), 32'(prev_addr));
        check("hold_data", 32'(mem_wdata), 32'(prev_data));
      end
      if (mem_we && mem_ready) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                   mem_addr, mem_wdata);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(w.addr));
          check("wr_data", 32'(mem_wdata), 32'(w.data));
        end
      end
      if (cmd_ok || cmd_err) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got ok=%0b err=%0b code=%0d, expected none",
                   cmd_ok, cmd_err, err_code);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_kind", {30'd0, cmd_err, cmd_ok}, r.err ? 32'd2 : 32'd1);
          if (r.err) check("err_code", 32'(err_code), 32'(r.code));
          check("rsp_cfg", 32'(cfg_out), 32'(r.cfg));
        end
      end
      prev_hold = mem_we && !mem_ready;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] s, b;
    int         typ, len;
    bit         bad;

    repeat (3) tick();
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_flags", {27'd0, busy, cmd_ok, cmd_err, err_code}, 32'd0);
    check("rst_cfg", 32'(cfg_out), 32'd0);
    rst_s = 1'b0;
    tick();

    // Configuration write, status one cycle after CHK.
    f = {8'hA5, 8'h43, 8'h3C, 8'h7F};
    run_frame(f, 1'b0, -1);
    check("c_ok_pulse", {31'd0, cmd_ok}, 32'd1);
    check("c_cfg", 32'(cfg_out), 32'h3C);
    check("c_busy_low", {31'd0, busy}, 32'd0);
    wait_done("c_frame");

    f = {8'hA5, 8'h57, 8'h00, 8'h01, 8'h00, 8'h02, 8'h11, 8'h22, 8'h8D};
    run_frame(f, 1'b0, -1);
    wait_done("w_good");
    f = {8'hA5, 8'h57, 8'h00, 8'h01, 8'h00, 8'h02, 8'h11, 8'h22, 8'h8E};
    run_frame(f, 1'b0, -1);
    check("w_bad_err", {31'd0, cmd_err}, 32'd1);
    check("w_bad_code", 32'(err_code), 32'd1);
    wait_done("w_badchk");

    // Erase with a stalling memory, then again with a byte injected mid-erase.
    rdy_mode = 2;
    f = {8'hA5, 8'h45, 8'h00, 8'h10, 8'h00, 8'h03, 8'h58};
    run_frame(f, 1'b0, -1);
    check("e_first_we", {31'd0, mem_we}, 32'd1);
    check("e_first_addr", 32'(mem_addr), 32'h001000);
    wait_done("e_toggle");
    run_frame(f, 1'b1, -1);
    wait_done("e_overrun");
    rdy_mode = 0;
    tick();

    // Back-to-back erase with ready high: LEN writes then cmd_ok.
    f = {8'hA5, 8'h45, 8'h00, 8'h20, 8'h00, 8'h04, 8'h69};
    run_frame(f, 1'b0, -1);
    repeat (4) tick();
    check("e_ok_timing", {31'd0, cmd_ok}, 32'd1);
    wait_done("e_fast");

    f = {8'hA5, 8'h57, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hBB};
    run_frame(f, 1'b0, -1);
    wait_done("w_wrap");

    f = {8'hA5, 8'h99};
    run_frame(f, 1'b0, -1);
    check("badopc_err", {31'd0, cmd_err}, 32'd1);
    check("badopc_code", 32'(err_code), 32'd0);
    wait_done("badopc");

    // Inter-byte timeout fires on the cycle after the count reaches TMO.
    push_rsp(1'b1, 2'd2);
    send_byte(8'hA5);
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (TMO) tick();
    check("tmo_not_yet", {31'd0, cmd_err}, 32'd0);
    check("tmo_busy", {31'd0, busy}, 32'd1);
    tick();
    check("tmo_err", {31'd0, cmd_err}, 32'd1);
    check("tmo_code", 32'(err_code), 32'd2);
    check("tmo_idle", {31'd0, busy}, 32'd0);
    wait_done("timeout");

    f = {8'hA5, 8'h57, 8'h00, 8'h00, 8'h00, 8'h01, 8'h77, 8'hCF};
    run_frame(f, 1'b0, 3);
    wait_done("tmo_edge");

    // Overrun: second data byte while the first write is still stalled.
    rdy_mode = 3;
    tick();
    wr_q.push_back('{addr: 24'h000200, data: 8'h11});
    push_rsp(1'b1, 2'd3);
    f = {8'hA5, 8'h57, 8'h00, 8'h02, 8'h00, 8'h02, 8'h11, 8'h22};
    foreach (f[i]) send_byte(f[i]);
    check("ovr_err", {31'd0, cmd_err}, 32'd1);
    check("ovr_code", 32'(err_code), 32'd3);
    rdy_mode = 0;
    wait_done("overrun");

    // Reset mid-frame with a write stalled.
    rdy_mode = 3;
    tick();
    f = {8'hA5, 8'h57, 8'h00, 8'h03, 8'h00, 8'h02, 8'h11};
    foreach (f[i]) send_byte(f[i]);
    rst_s = 1'b1;
    tick();
    check("mrst_we", {31'd0, mem_we}, 32'd0);
    check("mrst_addr", 32'(mem_addr), 32'd0);
    check("mrst_data", 32'(mem_wdata), 32'd0);
    check("mrst_cfg", 32'(cfg_out), 32'd0);
    check("mrst_flags", {27'd0, busy, cmd_ok, cmd_err, err_code}, 32'd0);
    cfg_exp = 8'h00;
    rst_s = 1'b0;
    rdy_mode = 0;
    tick();

    for (int n = 0; n < 40; n++) begin
      typ = $urandom_range(0, 4);
      bad = ($urandom_range(0, 3) == 0);
      rdy_mode = $urandom_range(0, 1);
      if (typ == 4) begin
        repeat ($urandom_range(1, 3)) begin
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h00;
          send_byte(b);
        end
        typ = 0;
      end
      f = {8'hA5};
      case (typ)
        0: begin
          f.push_back(8'h43);
          f.push_back(8'($urandom));
        end
        1, 2: begin
          f.push_back(typ == 1 ? 8'h57 : 8'h45);
          repeat (3) f.push_back(8'($urandom));
          len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
          f.push_back(8'(len));
          if (typ == 1) repeat ((len == 0) ? 256 : len) f.push_back(8'($urandom));
        end
        default: begin
          b = 8'($urandom);
          if (b == 8'h43 || b == 8'h45 || b == 8'h57) b = 8'h00;
          f.push_back(b);
        end
      endcase
      if (typ != 3) begin
        s = 8'h00;
        for (int i = 1; i < f.size(); i++) s = s + f[i];
        if (bad) s = s + 8'($urandom_range(1, 255));
        f.push_back(s);
      end
      run_frame(f, 1'b0, -1);
      wait_done("random");
    end
    rdy_mode = 0;
    repeat (4) tick();
    check("wr_q_empty", wr_q.size(), 32'd0);
    check("rsp_q_empty", rsp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
